pipe_ctrl_n: RTL and testbench

//   Parametrised pipeline controller for the openMIPS core; generalises the fixed
//   6-bit stall controller to NSTAGE stages.

---
 rtl/pipe_ctrl_n.sv | 121 ++++++++++++
 tb/tb_pipe_ctrl_n.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_n.sv
// rtl/pipe_ctrl_n.sv - NSTAGE pipeline stall controller with flush/redirect sequencing
// Also tracks a stall watchdog and a free-running stall-cycle count.
module pipe_ctrl_n #(
   parameter int                NSTAGE       = 6,
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] EXC_VEC      = ADDR_W'(32'h0000_0020),
   parameter int                FLUSH_CYCLES = 1,
   parameter int                WDOG_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTAGE-1:0] stallreq_i,
   input  logic              excp_valid_i,
   input  logic              eret_i,
   input  logic [ADDR_W-1:0] epc_i,
   input  logic              wdog_clr_i,
   output logic [NSTAGE-1:0] stall_o,
   output logic              flush_o,
   output logic              new_pc_valid_o,
   output logic [ADDR_W-1:0] new_pc_o,
   output logic              wdog_timeout_o,
   output logic [31:0]       stall_cnt_o
);

   localparam int              FC_W     = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FC_W-1:0] FC_LOAD  = FC_W'(FLUSH_CYCLES);
   localparam logic [FC_W-1:0] FC_ONE   = FC_W'(1);
   localparam logic [WDOG_W-1:0] WDOG_MAX = '1;
   localparam logic [WDOG_W-1:0] WDOG_PRE = WDOG_MAX - WDOG_W'(1);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t            state;
   logic [FC_W-1:0]   flush_cnt;
   logic [WDOG_W-1:0] wdog_cnt;
   logic [NSTAGE-1:0] stall_mask;
   logic              stall_any;
   logic              wdog_inc;

   // A stall at stage k must also freeze every older stage below it.
   always_comb begin
      logic acc;
      acc        = 1'b0;
      stall_mask = '0;
      for (int i = NSTAGE - 1; i >= 0; i--) begin
         acc           = acc | stallreq_i[i];
         stall_mask[i] = acc;
      end
   end

   assign stall_o   = (state == IDLE && !rst) ? stall_mask : '0;
   assign stall_any = |stall_o;
   assign wdog_inc  = (state == IDLE) && stall_any && !wdog_clr_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         flush_cnt      <= '0;
         flush_o        <= 1'b0;
         new_pc_valid_o <= 1'b0;
         new_pc_o       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (excp_valid_i || eret_i) begin
                  state          <= FLUSH;
                  flush_cnt      <= FC_LOAD;
                  flush_o        <= 1'b1;
                  new_pc_valid_o <= 1'b1;
                  new_pc_o       <= excp_valid_i ? EXC_VEC : epc_i;
               end else begin
                  flush_o        <= 1'b0;
                  new_pc_valid_o <= 1'b0;
               end
            end
            FLUSH: begin
               // Redirects here are dropped: nothing younger can commit while draining.
               new_pc_valid_o <= 1'b0;
               if (flush_cnt == FC_ONE) begin
                  state   <= IDLE;
                  flush_o <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - FC_ONE;
               end
            end
            default: begin
               state          <= IDLE;
               flush_o        <= 1'b0;
               new_pc_valid_o <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_cnt       <= '0;
         wdog_timeout_o <= 1'b0;
      end else begin
         if (!wdog_inc) begin
            wdog_cnt <= '0;
         end else if (wdog_cnt != WDOG_MAX) begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
         end
         if (wdog_clr_i) begin
            wdog_timeout_o <= 1'b0;
         end else if (wdog_inc && wdog_cnt >= WDOG_PRE) begin
            wdog_timeout_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_o <= '0;
      end else if (stall_any) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// tb/tb_pipe_ctrl_n.sv - directed self-checking bench for pipe_ctrl_n
// u_a uses default parameters; u_b has FLUSH_CYCLES=3, WDOG_W=4.
module tb_pipe_ctrl_n;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stallreq;
   logic        excp;
   logic        eret;
   logic [31:0] epc;
   logic        wdog_clr;

   logic [5:0]  stall_a, stall_b;
   logic        flush_a, flush_b, npv_a, npv_b, to_a, to_b;
   logic [31:0] npc_a, npc_b, cnt_a, cnt_b;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_ctrl_n u_a (
      .clk(clk), .rst(rst), .stallreq_i(stallreq), .excp_valid_i(excp),
      .eret_i(eret), .epc_i(epc), .wdog_clr_i(wdog_clr),
      .stall_o(stall_a), .flush_o(flush_a), .new_pc_valid_o(npv_a),
      .new_pc_o(npc_a), .wdog_timeout_o(to_a), .stall_cnt_o(cnt_a)
   );

   pipe_ctrl_n #(.FLUSH_CYCLES(3), .WDOG_W(4)) u_b (
      .clk(clk), .rst(rst), .stallreq_i(stallreq), .excp_valid_i(excp),
      .eret_i(eret), .epc_i(epc), .wdog_clr_i(wdog_clr),
      .stall_o(stall_b), .flush_o(flush_b), .new_pc_valid_o(npv_b),
      .new_pc_o(npc_b), .wdog_timeout_o(to_b), .stall_cnt_o(cnt_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; stallreq = '0; excp = 1'b0; eret = 1'b0; epc = '0; wdog_clr = 1'b0;
      #3;
      check("rst_stall", 32'(stall_a), 32'h0);
      check("rst_flush", 32'(flush_a), 32'h0);
      check("rst_npv",   32'(npv_a),   32'h0);
      check("rst_npc",   npc_a,        32'h0);
      check("rst_cnt",   cnt_a,        32'h0);
      check("rst_to",    32'(to_a),    32'h0);
      repeat (2) tick();
      rst = 1'b0;

      // combinational mask patterns, no edge consumed
      stallreq = 6'b000100; #1; check("mask_000100", 32'(stall_a), 32'h07);
      stallreq = 6'b100000; #1; check("mask_100000", 32'(stall_a), 32'h3f);
      stallreq = 6'b000001; #1; check("mask_000001", 32'(stall_a), 32'h01);
      stallreq = 6'b010010; #1; check("mask_010010", 32'(stall_a), 32'h1f);
      stallreq = 6'b000000; #1; check("mask_none",   32'(stall_a), 32'h00);

      // test 1: held stall for 3 cycles
      stallreq = 6'b001000;
      for (int i = 0; i < 3; i++) begin
         #1; check("t1_stall", 32'(stall_a), 32'h0f);
         tick();
      end
      check("t1_cnt",   cnt_a,        32'd3);
      check("t1_flush", 32'(flush_a), 32'h0);
      stallreq = '0;

      // test 2: exception redirect
      stallreq = 6'b000100; excp = 1'b1; #1;
      check("t2_stall_T", 32'(stall_a), 32'h07);
      tick();
      excp = 1'b0; #1;
      check("t2_flush", 32'(flush_a), 32'h1);
      check("t2_npv",   32'(npv_a),   32'h1);
      check("t2_npc",   npc_a,        32'h20);
      check("t2_stall", 32'(stall_a), 32'h0);
      check("t2_cnt",   cnt_a,        32'd4);
      tick();
      check("t2_flush_end", 32'(flush_a), 32'h0);
      check("t2_npv_end",   32'(npv_a),   32'h0);
      check("t2_stall_end", 32'(stall_a), 32'h07);
      stallreq = '0;

      // test 3: priority and ERET target
      excp = 1'b1; eret = 1'b1; epc = 32'h0000_1000;
      tick();
      excp = 1'b0; eret = 1'b0;
      check("t3_both_npc",   npc_a,        32'h20);
      check("t3_both_flush", 32'(flush_a), 32'h1);
      tick();
      eret = 1'b1;
      tick();
      eret = 1'b0;
      check("t3_eret_npc", npc_a,      32'h0000_1000);
      check("t3_eret_npv", 32'(npv_a), 32'h1);
      tick();
      check("t3_eret_done", 32'(flush_a), 32'h0);

      // test 4: multi-cycle flush on u_b, second exception ignored
      repeat (4) tick();
      check("t4_idle", 32'(flush_b), 32'h0);
      excp = 1'b1;
      tick();
      check("t4_c1_flush", 32'(flush_b), 32'h1);
      check("t4_c1_npv",   32'(npv_b),   32'h1);
      check("t4_c1_npc",   npc_b,        32'h20);
      eret = 1'b1; epc = 32'h0000_2000;
      tick();
      excp = 1'b0; eret = 1'b0;
      check("t4_c2_flush", 32'(flush_b), 32'h1);
      check("t4_c2_npv",   32'(npv_b),   32'h0);
      tick();
      check("t4_c3_flush", 32'(flush_b), 32'h1);
      check("t4_c3_npv",   32'(npv_b),   32'h0);
      tick();
      check("t4_c4_flush", 32'(flush_b), 32'h0);
      tick();
      check("t4_c5_flush", 32'(flush_b), 32'h0);
      check("t4_c5_npv",   32'(npv_b),   32'h0);
      check("t4_npc_kept", npc_b,        32'h20);

      // test 5: watchdog on u_b
      check("t5_to_init", 32'(to_b), 32'h0);
      stallreq = 6'b000001;
      repeat (14) tick();
      check("t5_to_14", 32'(to_b), 32'h0);
      tick();
      check("t5_to_15", 32'(to_b), 32'h1);
      check("t5_cnt_a", cnt_a,     32'd19);
      stallreq = '0;
      tick();
      check("t5_sticky", 32'(to_b), 32'h1);
      wdog_clr = 1'b1;
      tick();
      wdog_clr = 1'b0;
      check("t5_clr", 32'(to_b), 32'h0);

      // test 6: async reset mid-flush
      excp = 1'b1;
      tick();
      excp = 1'b0;
      check("t6_in_flush", 32'(flush_a), 32'h1);
      stallreq = 6'b000010;
      #1 rst = 1'b1;
      #1;
      check("t6_flush", 32'(flush_a), 32'h0);
      check("t6_npv",   32'(npv_a),   32'h0);
      check("t6_npc",   npc_a,        32'h0);
      check("t6_cnt",   cnt_a,        32'h0);
      check("t6_stall", 32'(stall_a), 32'h0);
      check("t6_to",    32'(to_a),    32'h0);
      tick();
      rst = 1'b0; #1;
      check("t6_idle_stall", 32'(stall_a), 32'h03);
      check("t6_idle_flush", 32'(flush_a), 32'h0);
      check("t6_cnt_rel",    cnt_a,        32'h0);
      tick();
      check("t6_cnt_run", cnt_a, 32'd1);
      stallreq = '0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
